// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S frame feeder.
// Optional build macro used by the feeder: I2S_FEEDER_MUTE_ON_UNDERRUN_EN.
package i2s_pkg;

    localparam int unsigned DEF_BITSIZE = 24;
    localparam int unsigned DEF_WORD    = 32;
    localparam int unsigned DEF_FRAME   = 2 * DEF_WORD;

    typedef struct packed {
        logic [DEF_BITSIZE-1:0] left;
        logic [DEF_BITSIZE-1:0] right;
    } pair_t;

    function automatic int unsigned frame_len(input int unsigned word);
        return 2 * word;
    endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous FIFO of stereo pairs; pointers wrap naturally, occupancy kept as a separate counter.
module i2s_sample_fifo #(
    parameter int unsigned Width = 48,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   level_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic             push_ok, pop_ok;

    assign full_o  = (level_q == LvlW'(Depth));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Overflow and underflow requests are dropped here as well as upstream.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/i2s_frame_feeder.sv
// Buffers stereo pairs and drives lrclk plus held channel words for the I2S transmitter.
// Define I2S_FEEDER_MUTE_ON_UNDERRUN_EN to output zeros on underrun instead of repeating.
module i2s_frame_feeder
    import i2s_pkg::*;
#(
    parameter int unsigned BITSIZE = DEF_BITSIZE,
    parameter int unsigned WORD    = DEF_WORD,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     sclk,
    input  logic                     rst,
    input  logic [BITSIZE-1:0]       in_left,
    input  logic [BITSIZE-1:0]       in_right,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     lrclk,
    output logic [BITSIZE-1:0]       left_chan,
    output logic [BITSIZE-1:0]       right_chan,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned Frame = frame_len(WORD);
    localparam int unsigned CntW  = $clog2(Frame);
    localparam logic [CntW-1:0] LastCnt = CntW'(Frame - 1);
    localparam logic [CntW-1:0] PopCnt  = CntW'(Frame - 2);
    localparam logic [CntW-1:0] WordCnt = CntW'(WORD);

    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               lrclk_q, lrclk_d;
    logic               run_q;
    logic [BITSIZE-1:0] left_q, left_d;
    logic [BITSIZE-1:0] right_q, right_d;
    logic               underrun_q, underrun_d;

    logic                 push, pop, at_pop;
    logic                 fifo_full, fifo_empty;
    logic [2*BITSIZE-1:0] fifo_head;

    // run_q keeps in_ready low while reset is held, using registered state only.
    assign in_ready   = run_q && !fifo_full;
    assign push       = in_valid && in_ready;
    assign at_pop     = (cnt_q == PopCnt);
    assign pop        = at_pop && !fifo_empty;

    assign lrclk      = lrclk_q;
    assign left_chan  = left_q;
    assign right_chan = right_q;
    assign underrun   = underrun_q;

    i2s_sample_fifo #(
        .Width (2 * BITSIZE),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (sclk),
        .rst_ni  (rst),
        .push_i  (push),
        .wdata_i ({in_left, in_right}),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    always_comb begin
        cnt_d      = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
        lrclk_d    = (cnt_d < WordCnt);
        left_d     = left_q;
        right_d    = right_q;
        underrun_d = 1'b0;
        if (at_pop) begin
            if (!fifo_empty) begin
                {left_d, right_d} = fifo_head;
            end else begin
                underrun_d = 1'b1;
`ifdef I2S_FEEDER_MUTE_ON_UNDERRUN_EN
                left_d     = '0;
                right_d    = '0;
`endif
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (!rst) begin
            cnt_q      <= LastCnt;
            lrclk_q    <= 1'b0;
            run_q      <= 1'b0;
            left_q     <= '0;
            right_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            lrclk_q    <= lrclk_d;
            run_q      <= 1'b1;
            left_q     <= left_d;
            right_q    <= right_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_i2s_frame_feeder.sv
// Directed bench for i2s_frame_feeder: vector table plus hand sequences for fill, collision, reset.
module tb_i2s_frame_feeder;
    import i2s_pkg::*;

`ifdef I2S_FEEDER_MUTE_ON_UNDERRUN_EN
    localparam bit Mute = 1'b1;
`else
    localparam bit Mute = 1'b0;
`endif

    logic        sclk;
    logic        rst;
    logic [23:0] in_left, in_right;
    logic        in_valid;
    logic        in_ready;
    logic        lrclk;
    logic [23:0] left_chan, right_chan;
    logic        underrun;
    logic [2:0]  level;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    i2s_frame_feeder #(
        .BITSIZE (24),
        .WORD    (32),
        .DEPTH   (4)
    ) dut (
        .sclk       (sclk),
        .rst        (rst),
        .in_left    (in_left),
        .in_right   (in_right),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .lrclk      (lrclk),
        .left_chan  (left_chan),
        .right_chan (right_chan),
        .underrun   (underrun),
        .level      (level)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    typedef struct {
        bit          rs;
        int          cyc;
        bit          vld;
        logic [23:0] l;
        logic [23:0] r;
        bit          e_lr;
        bit          e_und;
        int          e_lvl;
        logic [23:0] e_l;
        logic [23:0] e_r;
        bit          e_rdy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) begin
            step();
            cyc++;
            in_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        chk("rst_lrclk", 32'(lrclk), 32'd0);
        chk("rst_left", 32'(left_chan), 32'd0);
        chk("rst_right", 32'(right_chan), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        step();
        cyc = 0;
    endtask

    int   und_cnt;
    pair_t p;

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_left  = '0;
        in_right = '0;

        // No producer: frame timing and periodic underrun.
        tbl.push_back('{1,   0, 0, 24'h0, 24'h0, 1, 0, 0, 24'h0, 24'h0, 1});
        tbl.push_back('{0,  31, 0, 24'h0, 24'h0, 1, 0, 0, 24'h0, 24'h0, 1});
        tbl.push_back('{0,  32, 0, 24'h0, 24'h0, 0, 0, 0, 24'h0, 24'h0, 1});
        tbl.push_back('{0,  62, 0, 24'h0, 24'h0, 0, 0, 0, 24'h0, 24'h0, 1});
        tbl.push_back('{0,  63, 0, 24'h0, 24'h0, 0, 1, 0, 24'h0, 24'h0, 1});
        tbl.push_back('{0,  64, 0, 24'h0, 24'h0, 1, 0, 0, 24'h0, 24'h0, 1});
        tbl.push_back('{0,  95, 0, 24'h0, 24'h0, 1, 0, 0, 24'h0, 24'h0, 1});
        tbl.push_back('{0,  96, 0, 24'h0, 24'h0, 0, 0, 0, 24'h0, 24'h0, 1});
        tbl.push_back('{0, 127, 0, 24'h0, 24'h0, 0, 1, 0, 24'h0, 24'h0, 1});
        tbl.push_back('{0, 128, 0, 24'h0, 24'h0, 1, 0, 0, 24'h0, 24'h0, 1});
        // Single push at cycle 10.
        tbl.push_back('{1,  10, 1, 24'h123456, 24'hABCDEF, 1, 0, 0, 24'h0, 24'h0, 1});
        tbl.push_back('{0,  11, 0, 24'h0, 24'h0, 1, 0, 1, 24'h0, 24'h0, 1});
        tbl.push_back('{0,  62, 0, 24'h0, 24'h0, 0, 0, 1, 24'h0, 24'h0, 1});
        tbl.push_back('{0,  63, 0, 24'h0, 24'h0, 0, 0, 0, 24'h123456, 24'hABCDEF, 1});
        tbl.push_back('{0,  64, 0, 24'h0, 24'h0, 1, 0, 0, 24'h123456, 24'hABCDEF, 1});
        tbl.push_back('{0, 126, 0, 24'h0, 24'h0, 0, 0, 0, 24'h123456, 24'hABCDEF, 1});

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rs) do_reset();
            run_to(tbl[i].cyc);
            chk("tbl_lrclk", 32'(lrclk), 32'(tbl[i].e_lr));
            chk("tbl_underrun", 32'(underrun), 32'(tbl[i].e_und));
            chk("tbl_level", 32'(level), 32'(tbl[i].e_lvl));
            chk("tbl_left", 32'(left_chan), 32'(tbl[i].e_l));
            chk("tbl_right", 32'(right_chan), 32'(tbl[i].e_r));
            chk("tbl_ready", 32'(in_ready), 32'(tbl[i].e_rdy));
            in_valid = tbl[i].vld;
            in_left  = tbl[i].l;
            in_right = tbl[i].r;
        end

        // Fill to DEPTH, overflow attempts ignored, in-order drain, then underrun.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            chk("fill_level", 32'(level), 32'(k));
            chk("fill_ready", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_left  = 24'(32'h100 + k);
            in_right = 24'(32'h200 + k);
            step();
            cyc++;
        end
        chk("full_level", 32'(level), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        in_left  = 24'hBAD;
        in_right = 24'hBAD;
        for (int k = 0; k < 6; k++) begin
            step();
            cyc++;
        end
        in_valid = 1'b0;
        chk("full_hold_level", 32'(level), 32'd4);
        run_to(62);
        chk("full_pop_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        run_to(63);
        chk("drain0_left", 32'(left_chan), 32'h100);
        chk("drain0_right", 32'(right_chan), 32'h200);
        chk("drain0_level", 32'(level), 32'd3);
        chk("drain0_ready", 32'(in_ready), 32'd1);
        chk("drain0_und", 32'(underrun), 32'd0);
        for (int k = 1; k < 4; k++) begin
            run_to(63 + 64 * k);
            chk("drain_left", 32'(left_chan), 32'(32'h100 + k));
            chk("drain_right", 32'(right_chan), 32'(32'h200 + k));
            chk("drain_level", 32'(level), 32'(3 - k));
            chk("drain_und", 32'(underrun), 32'd0);
        end
        run_to(319);
        chk("drain_end_und", 32'(underrun), 32'd1);
        chk("drain_end_left", 32'(left_chan), Mute ? 32'd0 : 32'h103);

        // Push landing on the pop point of an empty FIFO.
        do_reset();
        run_to(62);
        p.left   = 24'h0A0B0C;
        p.right  = 24'h0D0E0F;
        in_valid = 1'b1;
        in_left  = p.left;
        in_right = p.right;
        run_to(63);
        chk("coll_und", 32'(underrun), 32'd1);
        chk("coll_level", 32'(level), 32'd1);
        chk("coll_left", 32'(left_chan), 32'd0);
        run_to(127);
        chk("coll_out_left", 32'(left_chan), 32'(p.left));
        chk("coll_out_right", 32'(right_chan), 32'(p.right));
        chk("coll_out_und", 32'(underrun), 32'd0);
        chk("coll_out_level", 32'(level), 32'd0);

        // Underrun after a single pair: repeat vs mute, exactly one pulse.
        do_reset();
        run_to(5);
        in_valid = 1'b1;
        in_left  = 24'h000001;
        in_right = 24'h000002;
        run_to(63);
        chk("ur_first_left", 32'(left_chan), 32'h1);
        chk("ur_first_und", 32'(underrun), 32'd0);
        und_cnt = 0;
        while (cyc < 190) begin
            step();
            cyc++;
            if (underrun === 1'b1) und_cnt++;
            if (cyc == 127) begin
                chk("ur_left", 32'(left_chan), Mute ? 32'd0 : 32'h1);
                chk("ur_right", 32'(right_chan), Mute ? 32'd0 : 32'h2);
            end
        end
        chk("ur_pulse_count", 32'(und_cnt), 32'd1);

        // Reset in mid-frame with a partly filled FIFO.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_left  = 24'(32'h300 + k);
            in_right = 24'(32'h400 + k);
            step();
            cyc++;
        end
        in_valid = 1'b0;
        run_to(20);
        chk("mid_level_pre", 32'(level), 32'd3);
        rst = 1'b0;
        step();
        chk("mid_level", 32'(level), 32'd0);
        chk("mid_lrclk", 32'(lrclk), 32'd0);
        chk("mid_left", 32'(left_chan), 32'd0);
        chk("mid_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        step();
        cyc = 0;
        chk("restart_lrclk", 32'(lrclk), 32'd1);
        chk("restart_ready", 32'(in_ready), 32'd1);
        run_to(32);
        chk("restart_lrclk_low", 32'(lrclk), 32'd0);
        run_to(63);
        chk("restart_und", 32'(underrun), 32'd1);
        chk("restart_left", 32'(left_chan), 32'd0);
        chk("restart_level", 32'(level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
